// File: rtl/bidir_link_ctrl.sv
// Half-duplex single-wire UART-style link: one shared pad, 8N1 frames, receive has priority,
// and a guard time after each transmit before the line can be listened to again.
module bidir_link_ctrl #(
    parameter int CLKS_PER_BIT = 8,
    parameter int TURN_BITS    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       pad_out,
    output logic       pad_oe,
    input  logic       pad_in,
    output logic [2:0] dbg_state_o
);
    // tx handshake: a byte moves on a clk edge where tx_valid and tx_ready are both 1;
    // tx_valid must stay high with stable tx_data until that edge.

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TX_START = 3'd1,
        S_TX_DATA  = 3'd2,
        S_TX_STOP  = 3'd3,
        S_TURN     = 3'd4,
        S_RX_START = 3'd5,
        S_RX_DATA  = 3'd6,
        S_RX_STOP  = 3'd7
    } state_t;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    TURN_LAST = 4'(TURN_BITS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    turn_q, turn_d;
    logic [7:0]    tx_buf_q, tx_buf_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_wait_q, rx_wait_d;
    logic          pad_out_q, pad_out_d;
    logic          pad_oe_q, pad_oe_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_err_q, rx_err_d;
    logic          sync1_q, sync2_q, line_prev_q;

    logic line;
    logic cnt_last;
    logic start_edge;

    assign line       = sync2_q;
    assign cnt_last   = (cnt_q == CNT_LAST);
    assign start_edge = line_prev_q & ~line & ~pad_oe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            turn_q      <= '0;
            tx_buf_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_wait_q   <= 1'b0;
            pad_out_q   <= 1'b1;
            pad_oe_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            turn_q      <= turn_d;
            tx_buf_q    <= tx_buf_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_wait_q   <= rx_wait_d;
            pad_out_q   <= pad_out_d;
            pad_oe_q    <= pad_oe_d;
            rx_valid_q  <= rx_valid_d;
            rx_err_q    <= rx_err_d;
            sync1_q     <= pad_in;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        turn_d     = turn_q;
        tx_buf_d   = tx_buf_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_wait_d  = rx_wait_q;
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                bit_d  = '0;
                turn_d = '0;
                // A start edge beats a pending transmit; the request simply waits.
                if (start_edge) begin
                    state_d = S_RX_START;
                end else if (tx_valid) begin
                    state_d  = S_TX_START;
                    tx_buf_d = tx_data;
                end
            end
            S_TX_START: begin
                if (cnt_last) begin
                    state_d = S_TX_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_TX_DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) state_d = S_TX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_TX_STOP: begin
                if (cnt_last) begin
                    state_d = S_TURN;
                    cnt_d   = '0;
                    turn_d  = '0;
                end
            end
            S_TURN: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (turn_q == TURN_LAST) state_d = S_IDLE;
                    else                     turn_d  = turn_q + 4'd1;
                end
            end
            S_RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = line ? S_IDLE : S_RX_DATA;
                end
            end
            S_RX_DATA: begin
                if (cnt_last) begin
                    cnt_d      = '0;
                    rx_shift_d = {line, rx_shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_RX_STOP: begin
                // After a bad stop bit, hold here until the line is released.
                if (rx_wait_q) begin
                    cnt_d = '0;
                    if (line) begin
                        state_d   = S_IDLE;
                        rx_wait_d = 1'b0;
                    end
                end else if (cnt_last) begin
                    cnt_d = '0;
                    if (line) begin
                        rx_data_d = rx_shift_q;
                        state_d   = S_IDLE;
                    end else begin
                        rx_wait_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pad outputs are registered from the next state, so they change on the same edge as it.
    always_comb begin
        pad_oe_d   = (state_d == S_TX_START) || (state_d == S_TX_DATA) || (state_d == S_TX_STOP);
        pad_out_d  = 1'b1;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        if (state_d == S_TX_START) pad_out_d = 1'b0;
        if (state_d == S_TX_DATA)  pad_out_d = tx_buf_d[bit_d];
        if ((state_q == S_RX_STOP) && !rx_wait_q && cnt_last) begin
            rx_valid_d = line;
            rx_err_d   = ~line;
        end
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_err      = rx_err_q;
    assign pad_out     = pad_out_q;
    assign pad_oe      = pad_oe_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bidir_link_ctrl.sv
// Bench for bidir_link_ctrl: the pad is modelled as a pulled-up wire shared with a remote
// transmitter; frames, glitches and transmits are checked against frame rules.
`timescale 1ns/1ps
module tb_bidir_link_ctrl;
    localparam int CPB = 8;
    localparam int TRN = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       pad_out;
    logic       pad_oe;
    logic       pad_in;
    logic [2:0] dbg_state;
    logic       remote_line = 1'b1;

    int passed = 0;
    int total  = 0;

    bidir_link_ctrl #(.CLKS_PER_BIT(CPB), .TURN_BITS(TRN)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .pad_out(pad_out), .pad_oe(pad_oe), .pad_in(pad_in),
        .dbg_state_o(dbg_state)
    );

    // Shared wire: our driver wins when enabled, otherwise the remote side (idle high).
    assign pad_in = pad_oe ? pad_out : remote_line;

    always #5 clk = ~clk;

    // Pulse / activity monitor, sampled on the falling edge.
    int   valid_cnt = 0, err_cnt = 0, oe_cnt = 0, busy_cnt = 0, valid_at_oe_rise = 0;
    logic oe_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid === 1'b1) valid_cnt++;
            if (rx_err === 1'b1) err_cnt++;
            if (pad_oe === 1'b1) oe_cnt++;
            if (tx_ready !== 1'b1) busy_cnt++;
            if (pad_oe === 1'b1 && oe_prev !== 1'b1) valid_at_oe_rise = valid_cnt;
        end
        oe_prev = pad_oe;
    end

    typedef struct {
        int         kind;      // 0 = frame from remote, 1 = low glitch
        logic [7:0] data;
        logic       stop;
        int         glen;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] model_rx;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    // Remote transmitter; call just after a falling edge.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        for (int b = 0; b < 10; b++) begin
            remote_line = (b == 9) ? stop : frame_bit(d, b);
            repeat (CPB) @(negedge clk);
        end
        remote_line = 1'b1;
    endtask

    // Transmit one byte and check the whole frame plus turnaround timing.
    task automatic do_tx(input logic [7:0] d, output int waited);
        int bad;
        tx_data  = d;
        tx_valid = 1'b1;
        waited   = 0;
        while (tx_ready !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("tx_accept_bound", int'(waited < 300), 1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (pad_oe !== 1'b1 || pad_out !== frame_bit(d, b)) bad++;
            end
            check($sformatf("tx_%02h_bit%0d_bad_cycles", d, b), bad, 0);
        end
        @(negedge clk);
        check("tx_release_oe", int'(pad_oe), 0);
        check("tx_release_out", int'(pad_out), 1);
        bad = 0;
        for (int c = 81; c < 96; c++) begin
            @(negedge clk);
            if (tx_ready !== 1'b0) bad++;
        end
        check("turn_ready_low_cycles_bad", bad, 0);
        @(negedge clk);
        check("ready_at_96", int'(tx_ready), 1);
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        int v0, e0, o0, b0, ok;
        v0 = valid_cnt; e0 = err_cnt; o0 = oe_cnt; b0 = busy_cnt;
        if (v.kind == 0) begin
            send_frame(v.data, v.stop);
        end else begin
            remote_line = 1'b0;
            repeat (v.glen) @(negedge clk);
            remote_line = 1'b1;
            ok = 0;
            for (int c = 0; c < 8 && ok == 0; c++) begin
                @(negedge clk);
                if (tx_ready === 1'b1 && busy_cnt != b0) ok = 1;
            end
            check({name, "_ready_within_8"}, ok, 1);
        end
        repeat (24) @(negedge clk);
        check({name, "_rx_valid_pulses"}, valid_cnt - v0, v.exp_valid);
        check({name, "_rx_err_pulses"}, err_cnt - e0, v.exp_err);
        check({name, "_rx_data"}, int'(rx_data), int'(v.exp_data));
        check({name, "_oe_during_rx"}, oe_cnt - o0, 0);
        check({name, "_seen_busy"}, int'(busy_cnt != b0), 1);
        check({name, "_idle_ready"}, int'(tx_ready), 1);
    endtask

    initial begin : main
        int   w, v0;
        vec_t rv;

        vecs[0] = '{0, 8'h3C, 1'b1, 0, 1, 0, 8'h3C};
        vecs[1] = '{0, 8'h55, 1'b0, 0, 0, 1, 8'h3C};
        vecs[2] = '{1, 8'h00, 1'b1, 2, 0, 0, 8'h3C};
        vecs[3] = '{0, 8'h00, 1'b1, 0, 1, 0, 8'h00};
        vecs[4] = '{0, 8'hFF, 1'b1, 0, 1, 0, 8'hFF};
        vecs[5] = '{0, 8'h81, 1'b0, 0, 0, 1, 8'hFF};
        vecs[6] = '{1, 8'h00, 1'b1, 3, 0, 0, 8'hFF};

        repeat (3) @(negedge clk);
        check("rst_pad_oe", int'(pad_oe), 0);
        check("rst_pad_out", int'(pad_out), 1);
        check("rst_tx_ready", int'(tx_ready), 1);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_rx_err", int'(rx_err), 0);
        check("rst_rx_data", int'(rx_data), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        do_tx(8'hA5, w);
        check("a5_first_edge_accept", w, 0);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Transmit request raised in the cycle the receiver sees the start edge.
        v0 = valid_cnt;
        fork
            send_frame(8'h96, 1'b1);
            begin
                repeat (2) @(negedge clk);
                tx_data  = 8'h69;
                tx_valid = 1'b1;
                @(negedge clk);
                check("sim_rx_wins_ready", int'(tx_ready), 0);
                do_tx(8'h69, w);
            end
        join
        check("sim_rx_valid_pulses", valid_cnt - v0, 1);
        check("sim_valid_before_oe", valid_at_oe_rise - v0, 1);
        check("sim_rx_data", int'(rx_data), 8'h96);
        repeat (4) @(negedge clk);

        // Reset in the middle of data bit 4 of a transmit.
        v0 = valid_cnt + err_cnt;
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (44) @(negedge clk);
        check("midtx_oe_before_rst", int'(pad_oe), 1);
        #2 rst = 1'b1;
        #1;
        check("midtx_rst_oe_async", int'(pad_oe), 0);
        check("midtx_rst_out_async", int'(pad_out), 1);
        check("midtx_rst_ready_async", int'(tx_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        check("midtx_rst_rx_data", int'(rx_data), 0);
        do_tx(8'h5A, w);
        check("post_rst_first_edge_accept", w, 0);
        check("midtx_no_rx_pulses", valid_cnt + err_cnt - v0, 0);
        repeat (4) @(negedge clk);

        // Randomized traffic against a frame-level model of the receiver.
        model_rx = 8'h00;
        for (int i = 0; i < 10; i++) begin
            int k;
            k = $urandom_range(0, 3);
            if (k == 0) begin
                do_tx(8'($urandom_range(0, 255)), w);
                repeat (3) @(negedge clk);
            end else begin
                rv.kind = (k == 3) ? 1 : 0;
                rv.data = 8'($urandom_range(0, 255));
                rv.stop = ($urandom_range(0, 3) != 0);
                rv.glen = $urandom_range(1, 3);
                rv.exp_valid = (rv.kind == 0 && rv.stop) ? 1 : 0;
                rv.exp_err   = (rv.kind == 0 && !rv.stop) ? 1 : 0;
                if (rv.exp_valid == 1) model_rx = rv.data;
                rv.exp_data  = model_rx;
                apply_vec(rv, $sformatf("rnd%0d", i));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
    end
endmodule
